// File: rtl/spi_adc_scanner.sv
// SPI master for MCP300x/MCP320x SAR ADCs.
// Single-shot or round-robin scan, SCLK divider, CS idle guard.
module spi_adc_scanner #(
    parameter int RES_BITS = 10,
    parameter int NUM_CH   = 2,
    parameter int SGL_DIFF = 1,
    parameter int CMD_MSBF = 1,
    parameter int GAP_BITS = 1,
    parameter int CLK_DIV  = 4,
    parameter int CS_IDLE  = 4,
    localparam int CH_W    = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CH_W-1:0]     ch_sel,
    input  logic                scan_en,
    output logic                busy,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    output logic                adc_din,
    input  logic                adc_dout,
    output logic [RES_BITS-1:0] sample_data,
    output logic [CH_W-1:0]     sample_ch,
    output logic                sample_valid
);

    localparam int CMD_LEN = 2 + CH_W + CMD_MSBF;
    localparam int FRAME   = CMD_LEN + GAP_BITS + RES_BITS;
    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int BIT_W   = $clog2(FRAME + 1);
    localparam int HOLD_W  = $clog2(CS_IDLE + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CS_HOLD
    } state_t;

    state_t state, state_d;

    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [CMD_LEN-1:0]  cmd_sr;
    logic [CMD_LEN-1:0]  cmd_word;
    logic [RES_BITS-1:0] data_sr;
    logic [CH_W-1:0]     cur_ch;
    logic [CH_W-1:0]     next_ch;
    logic [CH_W-1:0]     scan_ptr;
    logic                frame_done;
    logic                accept;
    logic                sclk_tog;
    logic                last_fall;
    logic                hold_done;

    always_comb begin
        next_ch   = scan_en ? scan_ptr : ch_sel;
        accept    = (state == IDLE) && (scan_en || start);
        sclk_tog  = (state == SHIFT) && (div_cnt == DIV_W'(CLK_DIV));
        last_fall = sclk_tog && adc_sclk && (bit_cnt == BIT_W'(FRAME));
        hold_done = (state == CS_HOLD) &&
                    (hold_cnt == HOLD_W'(CS_IDLE - 1));
    end

    // Bits after the start bit: SGL/DIFF, channel, optional MSBF, then 0.
    always_comb begin
        cmd_word = '0;
        cmd_word[CMD_LEN-1] = (SGL_DIFF != 0);
        cmd_word[CMD_LEN-2 -: CH_W] = next_ch;
        if (CMD_MSBF != 0) cmd_word[1] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (accept)    state_d = SHIFT;
            SHIFT:   if (last_fall) state_d = CS_HOLD;
            CS_HOLD: if (hold_done) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_cs_n     <= 1'b1;
            adc_sclk     <= 1'b0;
            adc_din      <= 1'b0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            hold_cnt     <= '0;
            cmd_sr       <= '0;
            data_sr      <= '0;
            cur_ch       <= '0;
            scan_ptr     <= '0;
            frame_done   <= 1'b0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
            sample_ch    <= '0;
        end else begin
            frame_done   <= 1'b0;
            sample_valid <= frame_done;
            if (frame_done) begin
                sample_data <= data_sr;
                sample_ch   <= cur_ch;
            end
            if (accept) begin
                adc_cs_n <= 1'b0;
                adc_din  <= 1'b1;
                adc_sclk <= 1'b0;
                div_cnt  <= '0;
                bit_cnt  <= '0;
                cmd_sr   <= cmd_word;
                cur_ch   <= next_ch;
                if (scan_en) begin
                    scan_ptr <= (scan_ptr == CH_W'(NUM_CH - 1)) ?
                                '0 : scan_ptr + 1'b1;
                end
            end else if (state == SHIFT) begin
                if (sclk_tog) begin
                    adc_sclk <= ~adc_sclk;
                    div_cnt  <= DIV_W'(1);
                    if (!adc_sclk) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt >= BIT_W'(CMD_LEN + GAP_BITS))
                            data_sr <= {data_sr[RES_BITS-2:0], adc_dout};
                        frame_done <= (bit_cnt == BIT_W'(FRAME - 1));
                    end else begin
                        adc_din <= cmd_sr[CMD_LEN-1];
                        cmd_sr  <= cmd_sr << 1;
                        if (bit_cnt == BIT_W'(FRAME)) begin
                            adc_cs_n <= 1'b1;
                            adc_din  <= 1'b0;
                            hold_cnt <= '0;
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end else if (state == CS_HOLD) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_adc_scanner.sv
// Directed bench for spi_adc_scanner: three configurations,
// each driven by a behavioural MCP-style ADC.
module tb_spi_adc_scanner;

    logic clk = 1'b0;
    logic rst_n;
    logic start_a [3];
    logic scan_en;
    logic scan_off;
    logic cs_a [3];
    logic sclk_a [3];
    logic din_a [3];
    logic dout_a [3];
    logic busy_a [3];
    logic vld_a [3];
    logic [0:0]  ch_sel0, ch_sel2, sc0, sc2;
    logic [2:0]  ch_sel1, sc1;
    logic [9:0]  sd0, sd1;
    logic [11:0] sd2;

    logic [11:0] adc_val [3][8];
    int vcnt [3] = '{0, 0, 0};
    int checks = 0;
    int errors = 0;
    longint t_hi = 0;
    longint hi_min = 1000;

    localparam int CMDL [3] = '{4, 5, 4};
    localparam int GAPB [3] = '{1, 2, 1};
    localparam int RESB [3] = '{10, 10, 12};
    localparam int MB   [3] = '{1, 0, 1};
    localparam int CHM  [3] = '{1, 7, 1};

    always #5 clk = ~clk;

    spi_adc_scanner u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]),
        .ch_sel(ch_sel0), .scan_en(scan_en), .busy(busy_a[0]),
        .adc_cs_n(cs_a[0]), .adc_sclk(sclk_a[0]),
        .adc_din(din_a[0]), .adc_dout(dout_a[0]),
        .sample_data(sd0), .sample_ch(sc0),
        .sample_valid(vld_a[0])
    );

    spi_adc_scanner #(
        .NUM_CH(8), .CMD_MSBF(0), .GAP_BITS(2)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]),
        .ch_sel(ch_sel1), .scan_en(scan_off), .busy(busy_a[1]),
        .adc_cs_n(cs_a[1]), .adc_sclk(sclk_a[1]),
        .adc_din(din_a[1]), .adc_dout(dout_a[1]),
        .sample_data(sd1), .sample_ch(sc1),
        .sample_valid(vld_a[1])
    );

    spi_adc_scanner #(
        .RES_BITS(12), .CLK_DIV(1)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_a[2]),
        .ch_sel(ch_sel2), .scan_en(scan_off), .busy(busy_a[2]),
        .adc_cs_n(cs_a[2]), .adc_sclk(sclk_a[2]),
        .adc_din(din_a[2]), .adc_dout(dout_a[2]),
        .sample_data(sd2), .sample_ch(sc2),
        .sample_valid(vld_a[2])
    );

    // ADC: latch DIN on SCLK rise, shift DOUT on SCLK fall.
    for (genvar g = 0; g < 3; g++) begin : gm
        int rc;
        int k;
        logic [7:0]  cap;
        logic [11:0] w;
        always @(negedge cs_a[g]) begin
            rc = 0;
            cap = '0;
            dout_a[g] = 1'b0;
        end
        always @(posedge sclk_a[g]) if (!cs_a[g]) begin
            rc++;
            if (rc <= CMDL[g]) cap = {cap[6:0], din_a[g]};
        end
        always @(negedge sclk_a[g]) if (!cs_a[g]) begin
            k = rc - CMDL[g] - GAPB[g];
            w = adc_val[g][(cap >> MB[g]) & CHM[g]];
            if (k >= 0 && k < RESB[g]) dout_a[g] = w[RESB[g]-1-k];
            else dout_a[g] = 1'b0;
        end
    end

    always @(posedge clk)
        for (int i = 0; i < 3; i++)
            if (vld_a[i] === 1'b1) vcnt[i]++;

    always @(posedge cs_a[0]) t_hi = $time;
    always @(negedge cs_a[0]) begin
        if (($time - t_hi) / 10 < hi_min) hi_min = ($time - t_hi) / 10;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_frame(input int g, input int lat, input int div);
        int n, r1, r2;
        logic prev;
        start_a[g] = 1'b1;
        tick();
        start_a[g] = 1'b0;
        chk("acc_cs", 32'(cs_a[g]), 0);
        chk("acc_busy", 32'(busy_a[g]), 1);
        chk("acc_din", 32'(din_a[g]), 1);
        n = 0; r1 = 0; r2 = 0; prev = 1'b0;
        while (vld_a[g] !== 1'b1 && n < 400) begin
            tick();
            n++;
            if (sclk_a[g] && !prev) begin
                if (r1 == 0) r1 = n;
                else if (r2 == 0) r2 = n;
            end
            prev = sclk_a[g];
        end
        chk("latency", n, lat);
        chk("rise1", r1, div + 1);
        chk("sclk_per", r2 - r1, 2 * div);
    endtask

    task automatic fin_frame(input int g);
        int n;
        tick();
        chk("vld_pulse", 32'(vld_a[g]), 0);
        n = 0;
        while (busy_a[g] && n < 100) begin
            tick();
            n++;
        end
        chk("idle", 32'(busy_a[g]), 0);
    endtask

    initial begin
        int v0, n, rises;
        logic prev;
        logic [9:0] exp_d [3];
        logic [0:0] exp_c [3];
        for (int i = 0; i < 3; i++) begin
            start_a[i] = 1'b0;
            for (int j = 0; j < 8; j++) adc_val[i][j] = '0;
        end
        rst_n = 1'b0;
        scan_en = 1'b0;
        scan_off = 1'b0;
        ch_sel0 = '0; ch_sel1 = '0; ch_sel2 = '0;
        repeat (3) tick();
        chk("rst_cs", 32'(cs_a[0]), 1);
        chk("rst_sclk", 32'(sclk_a[0]), 0);
        chk("rst_din", 32'(din_a[0]), 0);
        chk("rst_busy", 32'(busy_a[0]), 0);
        chk("rst_vld", 32'(vld_a[0]), 0);
        chk("rst_data", 32'(sd0), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // single-shot on channel 1
        adc_val[0][1] = 12'h2A5;
        ch_sel0 = 1'b1;
        v0 = vcnt[0];
        do_frame(0, 118, 4);
        chk("t1_data", 32'(sd0), 32'h2A5);
        chk("t1_ch", 32'(sc0), 1);
        chk("t1_cmd", 32'(gm[0].cap), 32'hF);
        fin_frame(0);
        chk("t1_cnt", vcnt[0] - v0, 1);

        // round-robin scan
        adc_val[0][0] = 12'h001;
        adc_val[0][1] = 12'h3FF;
        exp_d = '{10'h001, 10'h3FF, 10'h001};
        exp_c = '{1'b0, 1'b1, 1'b0};
        hi_min = 1000;
        v0 = vcnt[0];
        scan_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (vld_a[0] !== 1'b1 && n < 400) begin
                tick();
                n++;
            end
            chk("scan_to", 32'(n < 400), 1);
            chk("scan_data", 32'(sd0), 32'(exp_d[i]));
            chk("scan_ch", 32'(sc0), 32'(exp_c[i]));
            if (i == 2) scan_en = 1'b0;
            tick();
        end
        fin_frame(0);
        repeat (20) tick();
        chk("scan_cnt", vcnt[0] - v0, 3);
        chk("cs_gap", 32'(hi_min), 5);

        // start while busy is dropped
        adc_val[0][1] = 12'h1C3;
        ch_sel0 = 1'b1;
        v0 = vcnt[0];
        start_a[0] = 1'b1;
        tick();
        start_a[0] = 1'b0;
        repeat (9) tick();
        start_a[0] = 1'b1;
        ch_sel0 = 1'b0;
        tick();
        start_a[0] = 1'b0;
        n = 0;
        while (busy_a[0] && n < 300) begin
            tick();
            n++;
        end
        repeat (200) tick();
        chk("t3_cnt", vcnt[0] - v0, 1);
        chk("t3_data", 32'(sd0), 32'h1C3);
        chk("t3_ch", 32'(sc0), 1);

        // reset at sclk rise 8
        adc_val[0][0] = 12'h0F0;
        ch_sel0 = 1'b0;
        start_a[0] = 1'b1;
        tick();
        start_a[0] = 1'b0;
        rises = 0; prev = 1'b0; n = 0;
        while (rises < 8 && n < 200) begin
            tick();
            n++;
            if (sclk_a[0] && !prev) rises++;
            prev = sclk_a[0];
        end
        chk("t4_rise8", rises, 8);
        v0 = vcnt[0];
        rst_n = 1'b0;
        #1;
        chk("t4_cs", 32'(cs_a[0]), 1);
        chk("t4_sclk", 32'(sclk_a[0]), 0);
        chk("t4_busy", 32'(busy_a[0]), 0);
        chk("t4_data", 32'(sd0), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (150) tick();
        chk("t4_novld", vcnt[0] - v0, 0);
        do_frame(0, 118, 4);
        chk("t4b_data", 32'(sd0), 32'h0F0);
        chk("t4b_ch", 32'(sc0), 0);
        fin_frame(0);

        // 8-channel, no MSBF, two gap bits
        adc_val[1][5] = 12'h155;
        ch_sel1 = 3'd5;
        do_frame(1, 134, 4);
        chk("t5_data", 32'(sd1), 32'h155);
        chk("t5_ch", 32'(sc1), 5);
        chk("t5_cmd", 32'(gm[1].cap), 32'h1D);
        fin_frame(1);

        // 12-bit, fastest sclk
        adc_val[2][0] = 12'hABC;
        ch_sel2 = 1'b0;
        do_frame(2, 35, 1);
        chk("t6_data", 32'(sd2), 32'hABC);
        chk("t6_ch", 32'(sc2), 0);
        chk("t6_cmd", 32'(gm[2].cap), 32'hD);
        fin_frame(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
